// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster counters with combinational sync/blank/strobe decode
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [CW-1:0]      pixel_x,
  output logic [CW-1:0]      pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               display_area,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW1 = CW + 1;
  // decode constants are one bit wider so a window ending exactly at 2^CW still compares correctly
  localparam logic [CW:0] H_VIS = CW1'(H_VISIBLE);
  localparam logic [CW:0] H_S0  = CW1'(H_VISIBLE + H_FRONT);
  localparam logic [CW:0] H_S1  = CW1'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_VIS = CW1'(V_VISIBLE);
  localparam logic [CW:0] V_S0  = CW1'(V_VISIBLE + V_FRONT);
  localparam logic [CW:0] V_S1  = CW1'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);
  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW || H_VISIBLE == 0 || V_VISIBLE == 0 ||
      H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
    $error("vga_timing_gen: invalid timing configuration");
  end
  logic [CW-1:0] h_counter;
  logic [CW-1:0] v_counter;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW:0]   hx;
  logic [CW:0]   vx;
  assign h_wrap = h_counter == H_LAST;
  assign v_wrap = v_counter == V_LAST;
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_counter   <= '0;
      v_counter   <= '0;
      frame_count <= '0;
    end else if (pix_en) begin
      h_counter <= h_wrap ? '0 : h_counter + 1'b1;
      if (h_wrap) begin
        v_counter <= v_wrap ? '0 : v_counter + 1'b1;
        if (v_wrap) frame_count <= frame_count + 1'b1;
      end
    end
  end
  always_comb begin
    hx           = {1'b0, h_counter};
    vx           = {1'b0, v_counter};
    pixel_x      = h_counter;
    pixel_y      = v_counter;
    display_area = (hx < H_VIS) && (vx < V_VIS);
    vblank       = vx >= V_VIS;
    hsync        = (hx >= H_S0 && hx < H_S1) ? HP : ~HP;
    vsync        = (vx >= V_S0 && vx < V_S1) ? VP : ~VP;
    line_start   = pix_en && (h_counter == '0) && rst_n;
    frame_start  = line_start && (v_counter == '0);
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default 640x480 timing and a tiny 8x4 instance
module tb_vga_timing_gen;
  logic       clk, rst_n, pix_en;
  logic [9:0] px, py;
  logic       hs, vs, da, vb, ls, fs;
  logic [7:0] fc;
  logic       s_rst_n, s_en;
  logic [9:0] s_px, s_py;
  logic       s_hs, s_vs, s_da, s_vb, s_ls, s_fs;
  logic [7:0] s_fc;
  int checks = 0;
  int failures = 0;

  vga_timing_gen dut (
    .vga_clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_x(px), .pixel_y(py),
    .hsync(hs), .vsync(vs), .display_area(da), .vblank(vb), .line_start(ls),
    .frame_start(fs), .frame_count(fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1)
  ) dut_s (
    .vga_clk(clk), .rst_n(s_rst_n), .pix_en(s_en), .pixel_x(s_px), .pixel_y(s_py),
    .hsync(s_hs), .vsync(s_vs), .display_area(s_da), .vblank(s_vb), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_en = 1'b1;
    step();
    step();
    checks++;
    if ({px, py, da, vb, hs, vs, ls, fs, fc} !== {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_hold got x=%0d y=%0d da=%b vb=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want 0 0 1 0 1 1 0 0 0",
               px, py, da, vb, hs, vs, ls, fs, fc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({px, py, da, hs, vs, fc, fs, ls} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_release got x=%0d y=%0d da=%b hs=%b vs=%b fc=%0d fs=%b ls=%b want 0 0 1 1 1 0 1 1",
               px, py, da, hs, vs, fc, fs, ls);
    end
    step();
    checks++;
    if (px !== 10'd1 || py !== 10'd0) begin
      failures++;
      $display("FAIL first_edge got (%0d,%0d) want (1,0)", px, py);
    end
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (px !== 10'd0 || py !== 10'd0 || ls !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got (%0d,%0d) ls=%b want (0,0) ls=0", px, py, ls);
    end
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (px !== 10'd1 || py !== 10'd0) begin
      failures++;
      $display("FAIL after_async_reset got (%0d,%0d) want (1,0)", px, py);
    end
  endtask

  task automatic test_horizontal();
    int low;
    pix_en = 1'b0;
    force dut.v_counter = 10'd100;
    force dut.h_counter = 10'd656;
    #1;
    checks++;
    if (hs !== 1'b0 || da !== 1'b0) begin
      failures++;
      $display("FAIL h656 got hs=%b da=%b want 0 0", hs, da);
    end
    force dut.h_counter = 10'd752;
    #1;
    checks++;
    if (hs !== 1'b1) begin
      failures++;
      $display("FAIL h752 got hs=%b want 1", hs);
    end
    force dut.h_counter = 10'd655;
    #1;
    checks++;
    if (hs !== 1'b1) begin
      failures++;
      $display("FAIL h655 got hs=%b want 1", hs);
    end
    force dut.h_counter = 10'd639;
    force dut.v_counter = 10'd479;
    #1;
    checks++;
    if (da !== 1'b1) begin
      failures++;
      $display("FAIL h639_v479 got da=%b want 1", da);
    end
    force dut.h_counter = 10'd640;
    #1;
    checks++;
    if (da !== 1'b0) begin
      failures++;
      $display("FAIL h640 got da=%b want 0", da);
    end
    release dut.h_counter;
    release dut.v_counter;
    pix_en = 1'b1;
    low = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (hs === 1'b0) low++;
    end
    checks++;
    if (low != 96) begin
      failures++;
      $display("FAIL hsync_width got %0d want 96", low);
    end
  endtask

  task automatic test_vertical();
    pix_en = 1'b0;
    force dut.h_counter = 10'd200;
    force dut.v_counter = 10'd490;
    #1;
    checks++;
    if (vs !== 1'b0 || vb !== 1'b1) begin
      failures++;
      $display("FAIL v490 got vs=%b vb=%b want 0 1", vs, vb);
    end
    force dut.v_counter = 10'd492;
    #1;
    checks++;
    if (vs !== 1'b1) begin
      failures++;
      $display("FAIL v492 got vs=%b want 1", vs);
    end
    force dut.v_counter = 10'd479;
    #1;
    checks++;
    if (vb !== 1'b0 || vs !== 1'b1) begin
      failures++;
      $display("FAIL v479 got vb=%b vs=%b want 0 1", vb, vs);
    end
    release dut.h_counter;
    release dut.v_counter;
  endtask

  task automatic test_wrap();
    pix_en = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    force dut.h_counter = 10'd799;
    force dut.v_counter = 10'd524;
    #1;
    release dut.h_counter;
    release dut.v_counter;
    pix_en = 1'b1;
    step();
    checks++;
    if (px !== 10'd0 || py !== 10'd0 || fs !== 1'b1 || fc !== 8'd1) begin
      failures++;
      $display("FAIL frame_wrap got (%0d,%0d) fs=%b fc=%0d want (0,0) 1 1", px, py, fs, fc);
    end
  endtask

  task automatic test_enable();
    pix_en = 1'b0;
    force dut.h_counter = 10'd300;
    force dut.v_counter = 10'd0;
    #1;
    release dut.h_counter;
    release dut.v_counter;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (px !== 10'd300 || py !== 10'd0 || ls !== 1'b0 || fs !== 1'b0) begin
        failures++;
        $display("FAIL enable_hold cycle %0d got (%0d,%0d) ls=%b fs=%b want (300,0) 0 0", i, px, py, ls, fs);
      end
    end
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    step();
    pix_en = 1'b1;
    step();
    checks++;
    if (px !== 10'd302 || py !== 10'd0) begin
      failures++;
      $display("FAIL enable_toggle got (%0d,%0d) want (302,0)", px, py);
    end
  endtask

  task automatic test_params();
    int ex, ey, hs_hi, vs_hi;
    s_rst_n = 1'b1;
    s_en = 1'b1;
    ex = 0;
    ey = 0;
    hs_hi = 0;
    vs_hi = 0;
    for (int i = 0; i < 98; i++) begin
      checks++;
      if (s_px !== 10'(ex) || s_py !== 10'(ey) || s_hs !== (ex == 10 || ex == 11) || s_vs !== (ey == 5)) begin
        failures++;
        $display("FAIL small_trace cycle %0d got (%0d,%0d) hs=%b vs=%b want (%0d,%0d)", i, s_px, s_py, s_hs, s_vs, ex, ey);
      end
      if (s_hs === 1'b1) hs_hi++;
      if (s_vs === 1'b1) vs_hi++;
      step();
      ey = (ex == 13) ? ((ey == 6) ? 0 : ey + 1) : ey;
      ex = (ex == 13) ? 0 : ex + 1;
    end
    checks++;
    if (s_px !== 10'd0 || s_py !== 10'd0 || s_fs !== 1'b1 || s_fc !== 8'd1) begin
      failures++;
      $display("FAIL small_frame got (%0d,%0d) fs=%b fc=%0d want (0,0) 1 1", s_px, s_py, s_fs, s_fc);
    end
    checks++;
    if (hs_hi != 14 || vs_hi != 14) begin
      failures++;
      $display("FAIL small_sync_counts got hs=%0d vs=%0d want 14 14", hs_hi, vs_hi);
    end
    for (int i = 0; i < 254 * 98; i++) step();
    checks++;
    if (s_fc !== 8'd255) begin
      failures++;
      $display("FAIL frame_count_255 got %0d want 255", s_fc);
    end
    for (int i = 0; i < 98; i++) step();
    checks++;
    if (s_fc !== 8'd0 || s_fs !== 1'b1) begin
      failures++;
      $display("FAIL frame_count_wrap got fc=%0d fs=%b want 0 1", s_fc, s_fs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_en = 1'b0;
    s_rst_n = 1'b0;
    s_en = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_wrap();
    test_enable();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
